alu_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle datapath ALU. It keeps the existing 7-bit opcode set and adds iterative shift and multiply operations, a registered result, status flags and a start/busy/done handshake. It sits between the register-file read buses (busA/busB) and the write-back bus (busC), and the control unit sequences it.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 47 ++++
 rtl/alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_alu_mc.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and op classification for the multi-cycle ALU.
package alu_pkg;

    localparam logic [6:0] OP_PASSA  = 7'b0000011;
    localparam logic [6:0] OP_ONE    = 7'b0000111;
    localparam logic [6:0] OP_ADD    = 7'b0001011;
    localparam logic [6:0] OP_SUB    = 7'b0001111;
    localparam logic [6:0] OP_INC    = 7'b0010011;
    localparam logic [6:0] OP_DEC    = 7'b0010111;
    localparam logic [6:0] OP_PASSA2 = 7'b0100011;
    localparam logic [6:0] OP_PASSB  = 7'b0100111;
    localparam logic [6:0] OP_SLL    = 7'b0110011;
    localparam logic [6:0] OP_SRL    = 7'b0110111;
    localparam logic [6:0] OP_SRA    = 7'b0111011;
    localparam logic [6:0] OP_MUL    = 7'b0111111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_iterative(input logic [6:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle result and carry/overflow for the non-iterative opcodes.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [6:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] rhs;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    always_comb begin
        // INC/DEC reuse the adder and subtractor with a constant right operand
        rhs  = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
        sum  = {1'b0, a} + {1'b0, rhs};
        diff = {1'b0, a} - {1'b0, rhs};

        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_PASSA, OP_PASSA2: result = a;
            OP_ONE:              result = WIDTH'(1);
            OP_PASSB:            result = b;
            OP_ADD, OP_INC: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                // the extra MSB of the widened difference is the borrow
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != rhs[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: operands are sampled on start, single-cycle ops retire one edge
// later, shifts and multiply iterate one bit per cycle in the RUN state.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic [WIDTH-1:0] busC,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int CW = SHW + 1;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [6:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       funct3_unused_q, funct3_unused_d;
    logic [6:0]       funct7_unused_q, funct7_unused_d;
    logic [WIDTH-1:0] busc_q, busc_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] comb_result;
    logic             comb_carry;
    logic             comb_ovf;
    logic [CW-1:0]    run_len;
    logic             pend_iter;
    logic             last_step;
    logic             accept;
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] res;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (comb_result),
        .carry  (comb_carry),
        .ovf    (comb_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pend_q          <= 1'b0;
            op_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            acc_q           <= '0;
            cnt_q           <= '0;
            funct3_unused_q <= '0;
            funct7_unused_q <= '0;
            busc_q          <= '0;
            done_q          <= 1'b0;
            zero_q          <= 1'b0;
            carry_q         <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            op_q            <= op_d;
            a_q             <= a_d;
            b_q             <= b_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            funct3_unused_q <= funct3_unused_d;
            funct7_unused_q <= funct7_unused_d;
            busc_q          <= busc_d;
            done_q          <= done_d;
            zero_q          <= zero_d;
            carry_q         <= carry_d;
            ovf_q           <= ovf_d;
        end
    end

    always_comb begin
        run_len   = (op_q == OP_MUL) ? CW'(WIDTH) : {1'b0, b_q[SHW-1:0]};
        pend_iter = pend_q && is_iterative(op_q) && (run_len != '0);
        last_step = (cnt_q == CW'(1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pend_iter) state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_RUN);
        busC  = busc_q;
        done  = done_q;
        zero  = zero_q;
        carry = carry_q;
        ovf   = ovf_q;
    end

    // A launching iterative op still owns a_q/b_q, so a start arriving that cycle is dropped.
    assign accept = start && (state_q == ST_IDLE) && !pend_iter;

    always_comb begin
        case (op_q)
            OP_SRL:  a_step = a_q >> 1;
            OP_SRA:  a_step = $signed(a_q) >>> 1;
            default: a_step = a_q << 1;
        endcase
        acc_step = acc_q + (b_q[0] ? a_q : '0);

        pend_d          = 1'b0;
        op_d            = op_q;
        a_d             = a_q;
        b_d             = b_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        funct3_unused_d = funct3_unused_q;
        funct7_unused_d = funct7_unused_q;
        busc_d          = busc_q;
        done_d          = 1'b0;
        zero_d          = zero_q;
        carry_d         = carry_q;
        ovf_d           = ovf_q;
        res             = '0;

        if (state_q == ST_RUN) begin
            // During RUN a_q is the shifting value / multiplicand, b_q the multiplier.
            a_d   = a_step;
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
                b_d   = b_q >> 1;
                acc_d = acc_step;
            end
            if (last_step) begin
                res     = (op_q == OP_MUL) ? acc_step : a_step;
                busc_d  = res;
                zero_d  = (res == '0);
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                done_d  = 1'b1;
            end
        end else if (pend_q) begin
            if (pend_iter) begin
                cnt_d = run_len;
                acc_d = '0;
            end else begin
                res     = is_iterative(op_q) ? a_q : comb_result;
                busc_d  = res;
                zero_d  = (res == '0);
                carry_d = comb_carry;
                ovf_d   = comb_ovf;
                done_d  = 1'b1;
            end
        end

        if (accept) begin
            pend_d          = 1'b1;
            op_d            = op;
            a_d             = busA;
            b_d             = busB;
            funct3_unused_d = funct3;
            funct7_unused_d = funct7;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed vector bench for alu_mc plus hand sequences for busy, back-to-back and reset.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] busA, busB;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] busC;
    logic        busy, done, zero, carry, ovf;

    int total = 0;
    int bad   = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .busA(busA), .busB(busB),
        .op(op), .funct3(funct3), .funct7(funct7), .busC(busC),
        .busy(busy), .done(done), .zero(zero), .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [2:0]  flags;   // {zero, carry, ovf}
        int          cyc;     // edges from acceptance to done
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic busy1);
        @(negedge clk);
        op = o; busA = a; busB = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        busy1 = 1'b0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) busy1 = busy;
            if (done) break;
        end
    endtask

    initial begin
        int          cyc;
        logic        busy1;
        logic [31:0] held;
        logic        saw_done;

        vecs[0]  = '{7'b0001011, 32'hFFFFFFFF, 32'h1,        32'h0,        3'b110, 1};
        vecs[1]  = '{7'b0001111, 32'h80000000, 32'h1,        32'h7FFFFFFF, 3'b001, 1};
        vecs[2]  = '{7'b0001011, 32'h7FFFFFFF, 32'h1,        32'h80000000, 3'b001, 1};
        vecs[3]  = '{7'b0001011, 32'h80000000, 32'h80000000, 32'h0,        3'b111, 1};
        vecs[4]  = '{7'b0001111, 32'h1,        32'h2,        32'hFFFFFFFF, 3'b010, 1};
        vecs[5]  = '{7'b0010011, 32'h5,        32'hDEAD,     32'h6,        3'b000, 1};
        vecs[6]  = '{7'b0010011, 32'hFFFFFFFF, 32'h0,        32'h0,        3'b110, 1};
        vecs[7]  = '{7'b0010011, 32'h7FFFFFFF, 32'h0,        32'h80000000, 3'b001, 1};
        vecs[8]  = '{7'b0010111, 32'h0,        32'h0,        32'hFFFFFFFF, 3'b010, 1};
        vecs[9]  = '{7'b0010111, 32'h80000000, 32'h0,        32'h7FFFFFFF, 3'b001, 1};
        vecs[10] = '{7'b0000011, 32'h1234,     32'h5678,     32'h1234,     3'b000, 1};
        vecs[11] = '{7'b0000111, 32'h0,        32'h0,        32'h1,        3'b000, 1};
        vecs[12] = '{7'b0100011, 32'hCAFE,     32'hF00D,     32'hCAFE,     3'b000, 1};
        vecs[13] = '{7'b0100111, 32'hCAFE,     32'hF00D,     32'hF00D,     3'b000, 1};
        vecs[14] = '{7'b1111111, 32'h5,        32'h3,        32'h0,        3'b100, 1};
        vecs[15] = '{7'b0110011, 32'h1,        32'h1F,       32'h80000000, 3'b000, 32};
        vecs[16] = '{7'b0110111, 32'h80000000, 32'h4,        32'h08000000, 3'b000, 5};
        vecs[17] = '{7'b0111011, 32'h80000000, 32'h24,       32'hF8000000, 3'b000, 5};
        vecs[18] = '{7'b0111011, 32'h80000000, 32'h20,       32'h80000000, 3'b000, 1};
        vecs[19] = '{7'b0111111, 32'd12345,    32'd6789,     32'd83810205, 3'b000, 33};
        vecs[20] = '{7'b0111111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        3'b000, 33};
        vecs[21] = '{7'b0111011, 32'h7FFFFFFF, 32'h1F,       32'h0,        3'b100, 32};

        rst = 1'b1; start = 1'b0; busA = '0; busB = '0; op = '0;
        funct3 = 3'b101; funct7 = 7'h20;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {28'h0, busC, busy, done, zero, carry, ovf}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, busy1);
            $display("vec %0d op=%b a=%h b=%h -> busC=%h zco=%b cyc=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, busC, {zero, carry, ovf}, cyc);
            check($sformatf("v%0d_busC", i), {32'h0, busC}, {32'h0, vecs[i].c});
            check($sformatf("v%0d_flags", i), {61'h0, zero, carry, ovf}, {61'h0, vecs[i].flags});
            check($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].cyc));
            check($sformatf("v%0d_busy", i), {63'h0, busy1}, {63'h0, (vecs[i].cyc > 1)});
            check($sformatf("v%0d_busy_after_done", i), {63'h0, busy}, 64'h0);
            held = busC;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_single", i), {31'h0, done, busC}, {32'h0, held});
        end

        // start pulsed mid-MUL must be ignored entirely
        @(negedge clk);
        op = 7'b0111111; busA = 32'd7; busB = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            if (cyc == 5) begin
                @(negedge clk);
                op = 7'b0001011; busA = 32'd1; busB = 32'd1; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            cyc++;
            if (done) break;
        end
        $display("mul_ignore: busC=%h cyc=%0d", busC, cyc);
        check("mul_ignore_latency", 64'(cyc), 64'd33);
        check("mul_ignore_busC", {32'h0, busC}, 64'd63);
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("mul_ignore_no_extra_done", {31'h0, saw_done, busC}, 64'd63);

        // back-to-back: INC issued in the done cycle of SLL
        do_op(7'b0110011, 32'd3, 32'd2, cyc, busy1);
        $display("b2b sll: busC=%h cyc=%0d", busC, cyc);
        check("b2b_sll_busC", {32'h0, busC}, 64'd12);
        check("b2b_sll_latency", 64'(cyc), 64'd3);
        @(negedge clk);
        op = 7'b0010011; busA = 32'd5; busB = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_hold", {31'h0, done, busC}, 64'd12);
        @(posedge clk);
        #1;
        $display("b2b inc: busC=%h done=%b", busC, done);
        check("b2b_inc", {31'h0, done, busC}, {32'h1, 32'd6});

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        op = 7'b0111111; busA = 32'hFFFF; busB = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_mul_busy", {63'h0, busy}, 64'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("mid-mul reset: busC=%h busy=%b done=%b", busC, busy, done);
        check("mid_mul_reset_outputs", {28'h0, busC, busy, done, zero, carry, ovf}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("mid_mul_no_done", {63'h0, saw_done}, 64'h0);
        do_op(7'b1111111, 32'd5, 32'd3, cyc, busy1);
        $display("post-reset unlisted op: busC=%h zero=%b cyc=%0d", busC, zero, cyc);
        check("post_reset_busC_zero", {31'h0, zero, busC}, {32'h1, 32'h0});
        check("post_reset_latency", 64'(cyc), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
